// File: rtl/squeeznext_stall_pkg.sv
// rtl/squeeznext_stall_pkg.sv - shared FSM state type and default thresholds for the layer stall controller
package squeeznext_stall_pkg;

    typedef enum logic [1:0] {
        ST_RUN   = 2'd0,
        ST_STALL = 2'd1,
        ST_HOLD  = 2'd2
    } stall_state_t;

    localparam int DEF_DEPTH   = 512;
    localparam int DEF_CNT_W   = 10;
    localparam int DEF_HI_TH   = 480;
    localparam int DEF_LO_TH   = 256;
    localparam int DEF_MIN_RUN = 16;
    localparam int DEF_STAT_W  = 32;

endpackage

// File: rtl/layer_stall_ctrl_if.sv
// rtl/layer_stall_ctrl_if.sv - buffer events, gate requests and status of the layer stall controller
interface layer_stall_ctrl_if #(
    parameter int CNT_W  = 10,
    parameter int STAT_W = 32
);
    logic              wr_push;
    logic              rd_pop;
    logic              force_run;
    logic              CLK_EN;
    logic              CLK_Dis;
    logic              stalled;
    logic [CNT_W-1:0]  occupancy;
    logic              err;
    logic [STAT_W-1:0] stall_cycles;

    modport master (
        output wr_push, rd_pop, force_run,
        input  CLK_EN, CLK_Dis, stalled, occupancy, err, stall_cycles
    );

    modport slave (
        input  wr_push, rd_pop, force_run,
        output CLK_EN, CLK_Dis, stalled, occupancy, err, stall_cycles
    );
endinterface

// File: rtl/stall_occ_counter.sv
// rtl/stall_occ_counter.sv - inter-layer buffer word count with sticky overflow/underflow flag
module stall_occ_counter #(
    parameter int DEPTH = 512,
    parameter int CNT_W = 10
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             push,
    input  logic             pop,
    output logic [CNT_W-1:0] occupancy,
    output logic             err
);
    logic [CNT_W-1:0] occ_q;
    logic             err_q;

    // Simultaneous push and pop cancel, so they never flag an error even at full or empty.
    always_ff @(posedge clk) begin
        if (rst) begin
            occ_q <= '0;
            err_q <= 1'b0;
        end else begin
            case ({push, pop})
                2'b10: begin
                    if (occ_q == CNT_W'(DEPTH)) err_q <= 1'b1;
                    else                         occ_q <= occ_q + CNT_W'(1);
                end
                2'b01: begin
                    if (occ_q == '0) err_q <= 1'b1;
                    else             occ_q <= occ_q - CNT_W'(1);
                end
                default: ;
            endcase
        end
    end

    assign occupancy = occ_q;
    assign err       = err_q;
endmodule

// File: rtl/layer_stall_ctrl.sv
// rtl/layer_stall_ctrl.sv - producer clock-gate stall FSM; LAYER_STALL_CTRL_STATS_EN enables the stall cycle counter
module layer_stall_ctrl
    import squeeznext_stall_pkg::*;
#(
    parameter int DEPTH   = DEF_DEPTH,
    parameter int CNT_W   = DEF_CNT_W,
    parameter int HI_TH   = DEF_HI_TH,
    parameter int LO_TH   = DEF_LO_TH,
    parameter int MIN_RUN = DEF_MIN_RUN,
    parameter int STAT_W  = DEF_STAT_W
) (
    input  logic             clk,
    input  logic             rst,
    layer_stall_ctrl_if.slave bus
);
    localparam int HOLD_W = $clog2(MIN_RUN + 1);

    if (!(LO_TH < HI_TH && HI_TH <= DEPTH && MIN_RUN >= 1 && (1 << CNT_W) > DEPTH)) begin : g_bad_params
        $error("layer_stall_ctrl: illegal parameter set");
    end

    logic [CNT_W-1:0]  occ;
    logic              occ_err;
    stall_state_t      state_q, state_d;
    logic [HOLD_W-1:0] hold_q, hold_d;
    logic              en_q, en_d;
    logic              dis_q, dis_d;

    stall_occ_counter #(
        .DEPTH (DEPTH),
        .CNT_W (CNT_W)
    ) u_occ (
        .clk       (clk),
        .rst       (rst),
        .push      (bus.wr_push),
        .pop       (bus.rd_pop),
        .occupancy (occ),
        .err       (occ_err)
    );

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= ST_RUN;
            hold_q  <= '0;
            en_q    <= 1'b0;
            dis_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            hold_q  <= hold_d;
            en_q    <= en_d;
            dis_q   <= dis_d;
        end
    end

    // Decisions use the registered count, so each gate pulse lands one cycle after its trigger is visible.
    always_comb begin
        state_d = state_q;
        hold_d  = hold_q;
        en_d    = 1'b0;
        dis_d   = 1'b0;
        case (state_q)
            ST_RUN: begin
                if (occ >= CNT_W'(HI_TH) && !bus.force_run) begin
                    dis_d   = 1'b1;
                    state_d = ST_STALL;
                end
            end
            ST_STALL: begin
                if (occ <= CNT_W'(LO_TH) || bus.force_run) begin
                    en_d    = 1'b1;
                    hold_d  = HOLD_W'(MIN_RUN);
                    state_d = ST_HOLD;
                end
            end
            ST_HOLD: begin
                // A full buffer cannot wait out the minimum run time.
                if (occ == CNT_W'(DEPTH) && !bus.force_run) begin
                    dis_d   = 1'b1;
                    hold_d  = '0;
                    state_d = ST_STALL;
                end else if (hold_q <= HOLD_W'(1)) begin
                    hold_d  = '0;
                    state_d = ST_RUN;
                end else begin
                    hold_d  = hold_q - HOLD_W'(1);
                end
            end
            default: begin
                hold_d  = '0;
                state_d = ST_RUN;
            end
        endcase
    end

    // Reset forces the gate open immediately and hides any pulse left over from before it.
    assign bus.CLK_EN    = en_q | rst;
    assign bus.CLK_Dis   = dis_q & ~rst;
    assign bus.stalled   = (state_q == ST_STALL) & ~rst;
    assign bus.occupancy = occ;
    assign bus.err       = occ_err;

`ifdef LAYER_STALL_CTRL_STATS_EN
    logic [STAT_W-1:0] stall_q;

    always_ff @(posedge clk) begin
        if (rst) begin
            stall_q <= '0;
        end else if (state_q == ST_STALL && stall_q != '1) begin
            stall_q <= stall_q + STAT_W'(1);
        end
    end

    assign bus.stall_cycles = stall_q;
`else
    assign bus.stall_cycles = '0;
`endif
endmodule

// File: tb/tb_layer_stall_ctrl.sv
// tb/tb_layer_stall_ctrl.sv - scoreboard bench for layer_stall_ctrl against a cycle reference model
module tb_layer_stall_ctrl;
    localparam int DEPTH   = 16;
    localparam int CNT_W   = 5;
    localparam int HI_TH   = 12;
    localparam int LO_TH   = 4;
    localparam int MIN_RUN = 3;
    localparam int STAT_W  = 32;
    localparam longint STAT_MAX = (64'd1 << STAT_W) - 1;

    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    layer_stall_ctrl_if #(.CNT_W(CNT_W), .STAT_W(STAT_W)) bus ();

    layer_stall_ctrl #(
        .DEPTH   (DEPTH),
        .CNT_W   (CNT_W),
        .HI_TH   (HI_TH),
        .LO_TH   (LO_TH),
        .MIN_RUN (MIN_RUN),
        .STAT_W  (STAT_W)
    ) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    typedef struct {
        int     occ;
        bit     err;
        bit     stalled;
        bit     en;
        bit     dis;
        longint sc;
    } exp_t;

    exp_t sb[$];
    int errors = 0;
    int checks = 0;

    // Reference model: mode 0 = running, 1 = stalled, 2 = holding after a resume.
    int     m_occ  = 0;
    bit     m_err  = 0;
    int     m_mode = 0;
    int     m_hold = 0;
    longint m_sc   = 0;

    task automatic check(input string name, input longint act, input longint exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
        end
    endtask

    task automatic model_step(input bit r, input bit p, input bit q, input bit f);
        exp_t e;
        bit en = 0, dis = 0;
        int nmode;
        if (r) begin
            m_occ = 0; m_err = 0; m_mode = 0; m_hold = 0; m_sc = 0;
            en = 1;
        end else begin
            nmode = m_mode;
            if (m_mode == 0) begin
                if (m_occ >= HI_TH && !f) begin dis = 1; nmode = 1; end
            end else if (m_mode == 1) begin
                if (m_occ <= LO_TH || f) begin en = 1; m_hold = MIN_RUN; nmode = 2; end
            end else begin
                if (m_occ == DEPTH && !f) begin dis = 1; m_hold = 0; nmode = 1; end
                else begin
                    m_hold = m_hold - 1;
                    if (m_hold <= 0) begin m_hold = 0; nmode = 0; end
                end
            end
`ifdef LAYER_STALL_CTRL_STATS_EN
            if (m_mode == 1 && m_sc < STAT_MAX) m_sc = m_sc + 1;
`endif
            m_mode = nmode;
            if (p && !q) begin
                if (m_occ == DEPTH) m_err = 1; else m_occ = m_occ + 1;
            end else if (q && !p) begin
                if (m_occ == 0) m_err = 1; else m_occ = m_occ - 1;
            end
        end
        e.occ = m_occ; e.err = m_err; e.stalled = (m_mode == 1) && !r;
        e.en = en; e.dis = dis; e.sc = m_sc;
        sb.push_back(e);
    endtask

    task automatic cycle(input bit r, input bit p, input bit q, input bit f);
        @(negedge clk);
        rst = r; bus.wr_push = p; bus.rd_pop = q; bus.force_run = f;
        model_step(r, p, q, f);
    endtask

    task automatic repeat_cycle(input int n, input bit r, input bit p, input bit q, input bit f);
        for (int i = 0; i < n; i++) cycle(r, p, q, f);
    endtask

    initial begin : monitor
        exp_t e;
        forever begin
            @(posedge clk);
            #1;
            if (sb.size() > 0) begin
                e = sb.pop_front();
                check("occupancy",    longint'(bus.occupancy),    longint'(e.occ));
                check("err",          longint'(bus.err),          longint'(e.err));
                check("stalled",      longint'(bus.stalled),      longint'(e.stalled));
                check("CLK_EN",       longint'(bus.CLK_EN),       longint'(e.en));
                check("CLK_Dis",      longint'(bus.CLK_Dis),      longint'(e.dis));
                check("stall_cycles", longint'(bus.stall_cycles), e.sc);
            end
        end
    end

    initial begin : watchdog
        #200000;
        $display("FAIL timeout: got running expected finished");
        $fatal(1, "timeout");
    end

    initial begin : stimulus
        int pp, pq;
        rst = 1'b1; bus.wr_push = 1'b0; bus.rd_pop = 1'b0; bus.force_run = 1'b0;

        repeat_cycle(3, 1, 0, 0, 0);
        repeat_cycle(12, 0, 1, 0, 0);
        repeat_cycle(3, 0, 0, 0, 0);
        repeat_cycle(8, 0, 0, 1, 0);
        repeat_cycle(6, 0, 0, 0, 0);

        repeat_cycle(12, 0, 1, 0, 0);
        repeat_cycle(1, 0, 0, 0, 0);
        cycle(0, 1, 1, 0);
        repeat_cycle(1, 0, 0, 0, 0);
        cycle(0, 1, 0, 0);
        repeat_cycle(3, 0, 0, 0, 0);

        repeat_cycle(1, 1, 0, 0, 0);
        repeat_cycle(14, 0, 1, 0, 0);
        cycle(0, 1, 0, 1);
        cycle(0, 1, 0, 0);
        repeat_cycle(3, 0, 0, 0, 0);

        repeat_cycle(1, 1, 0, 0, 0);
        repeat_cycle(12, 0, 1, 0, 0);
        repeat_cycle(20, 0, 0, 0, 0);
        cycle(0, 0, 0, 1);
        repeat_cycle(4, 0, 0, 0, 0);

        repeat_cycle(1, 1, 0, 0, 0);
        for (int blk = 0; blk < 8; blk++) begin
            pp = (blk % 2 == 0) ? 70 : 30;
            pq = 100 - pp;
            for (int i = 0; i < 60; i++) begin
                cycle($urandom_range(0, 299) == 0,
                      $urandom_range(0, 99) < pp,
                      $urandom_range(0, 99) < pq,
                      $urandom_range(0, 15) == 0);
            end
        end
        repeat_cycle(2, 0, 0, 0, 0);

        for (int i = 0; i < 10 && sb.size() > 0; i++) @(posedge clk);
        @(posedge clk);
        #2;
        check("scoreboard_drain", longint'(sb.size()), 0);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule

// File: doc/layer_stall_ctrl.md
LAYER_STALL_CTRL -- requirements
Module: layer_stall_ctrl

Interface
REQ-001 SHALL have parameter DEPTH, default 512, capacity in words of the L1->L2 inter-layer buffer.
REQ-002 SHALL have parameter CNT_W, default 10, occupancy width (holds 0..DEPTH).
REQ-003 SHALL have parameter HI_TH, default 480, stall threshold in words.
REQ-004 SHALL have parameter LO_TH, default 256, resume threshold in words.
REQ-005 SHALL have parameter MIN_RUN, default 16, minimum cycles in HOLD after a resume.
REQ-006 SHALL have parameter STAT_W, default 32, stall statistics counter width.
REQ-007 SHALL have port clk  input  1  single free-running clock, ungated.
REQ-008 SHALL have port rst  input  1  synchronous, active-high reset.
REQ-009 SHALL have port wr_push  input  1  producer layer wrote one word into the buffer this cycle.
REQ-010 SHALL have port rd_pop  input  1  consumer layer read one word from the buffer this cycle.
REQ-011 SHALL have port force_run  input  1  override that blocks stalling and forces a resume.
REQ-012 SHALL have port CLK_EN  output  1  one-cycle request to open the producer clock gate.
REQ-013 SHALL have port CLK_Dis  output  1  one-cycle request to close the producer clock gate.
REQ-014 SHALL have port stalled  output  1  high while the FSM is in STALL.
REQ-015 SHALL have port occupancy  output  CNT_W  registered buffer word count.
REQ-016 SHALL have port err  output  1  sticky overflow/underflow flag.
REQ-017 SHALL have port stall_cycles  output  STAT_W  cycles spent in STALL.

Function
REQ-018 SHALL update occupancy as follows: +1 on push only, -1 on pop only, unchanged on both or neither.
REQ-019 SHALL ignore push when occupancy==DEPTH, leaving occupancy unchanged, and SHALL set err; push and pop together at DEPTH SHALL NOT set err.
REQ-020 SHALL ignore pop when occupancy==0 and set err; push and pop together at 0 SHALL leave occupancy 0 and err clear.
REQ-021 SHALL implement FSM states RUN, STALL and HOLD; all comparisons SHALL use the registered occupancy.
REQ-022 RUN: on occupancy>=HI_TH with force_run=0, SHALL register CLK_Dis=1 for the next cycle and enter STALL.
REQ-023 STALL: on occupancy<=LO_TH or force_run=1, SHALL register CLK_EN=1 for the next cycle, load the hold counter with MIN_RUN, and enter HOLD.
REQ-024 HOLD: SHALL decrement the hold counter each cycle, ignore HI_TH, and enter RUN when the counter reaches 0.
REQ-025 HOLD: on occupancy==DEPTH with force_run=0, SHALL issue CLK_Dis and enter STALL immediately, overriding MIN_RUN.
REQ-026 SHALL register CLK_EN and CLK_Dis, pulse each for exactly one cycle per transition, and never assert both in the same cycle.
REQ-027 Latency: the CLK_Dis/CLK_EN pulse SHALL be high in the cycle after the occupancy value that triggers it is first visible.
REQ-028 Parameter legality, checked at elaboration: LO_TH<HI_TH<=DEPTH, MIN_RUN>=1, 2^CNT_W>DEPTH.

Reset
REQ-029 While rst=1: occupancy=0, err=0, state=RUN, hold counter=0, stall_cycles=0, stalled=0, CLK_Dis=0, and CLK_EN=1 so the gate is forced open.
REQ-030 After rst deasserts, CLK_EN SHALL be 0 from the first cycle on; reset asserted in STALL or HOLD SHALL abandon the state with no pending pulse.

Configuration
REQ-031 Macro LAYER_STALL_CTRL_STATS_EN defined: stall_cycles SHALL increment once per cycle in STALL and saturate at all-ones.
REQ-032 Macro undefined: the stall_cycles port SHALL remain present and be tied to 0, and no counter logic SHALL be synthesized.

Structure
REQ-033 The FSM state typedef and default threshold constants SHALL reside in shared package squeeznext_stall_pkg.
REQ-034 The occupancy counter and err logic SHALL be one sub-module, stall_occ_counter; the FSM and hold counter SHALL stay in the top module.

Verification (DEPTH=16, CNT_W=5, HI_TH=12, LO_TH=4, MIN_RUN=3)
REQ-035 Hold rst high 3 cycles -> CLK_EN=1 for those 3 cycles then 0; occupancy=0; stalled=0; err=0.
REQ-036 Apply 12 consecutive pushes -> occupancy=12, then CLK_Dis=1 for exactly one cycle, then stalled=1.
REQ-037 From STALL apply 8 pops -> occupancy=4, then a single CLK_EN pulse, HOLD for 3 cycles, then RUN.
REQ-038 At occupancy 16, apply push+pop together -> occupancy stays 16, err=0; then push alone -> occupancy stays 16, err=1 and remains 1.
REQ-039 In HOLD, push to occupancy=16 -> CLK_Dis next cycle despite the remaining hold count, and the FSM enters STALL.
REQ-040 Stay in STALL 20 cycles then assert force_run -> CLK_EN next cycle; stall_cycles=20 with the macro defined, 0 without it.
